// File: rtl/program_loader.sv
// Encodes decoded instruction commands into 32-bit words and writes them to
// consecutive instruction-memory addresses, stalling the core while loading.
module program_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_opcode,
    input  logic [4:0]        cmd_dest,
    input  logic [4:0]        cmd_src1,
    input  logic [4:0]        cmd_src2,
    input  logic [15:0]       cmd_imm,
    input  logic              cmd_last,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned WC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t            state_q, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [WC_W-1:0]   wc_next;
    logic [ADDR_W-1:0] maddr_next;
    logic [31:0]       wdata_next;
    logic              w_en_next, done_next, ill_next, ovf_next;
    logic [31:0]       word_c;
    logic              illegal_c;
    logic [15:0]       offset_c;
    logic              accept_c;

    // Branch targets are absolute; the word carries target - (pc + 1).
    assign offset_c = 16'(cmd_imm - 16'(addr_q) - 16'd1);
    assign accept_c = cmd_valid && cmd_ready;

    // Instruction word encoder
    always_comb begin
        word_c    = 32'h0;
        illegal_c = 1'b0;
        case (cmd_opcode)
            OP_NOP: word_c = 32'h0;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL:
                word_c = {cmd_opcode, cmd_dest, cmd_src1, cmd_src2, 11'd0};
            OP_ADDI, OP_SUBI, OP_LD:
                word_c = {cmd_opcode, cmd_dest, cmd_src1, cmd_imm};
            OP_ST:  word_c = {cmd_opcode, cmd_src2, cmd_src1, cmd_imm};
            OP_BEZ: word_c = {cmd_opcode, cmd_src1, 5'd0, offset_c};
            OP_BNE: word_c = {cmd_opcode, cmd_src1, cmd_src2, offset_c};
            OP_JMP: word_c = {cmd_opcode, 10'd0, offset_c};
            default: begin
                word_c    = 32'h0;
                illegal_c = 1'b1;
            end
        endcase
    end

    // Next-state and next-register logic
    always_comb begin
        state_next = state_q;
        addr_next  = addr_q;
        wc_next    = word_count;
        w_en_next  = 1'b0;
        maddr_next = mem_addr;
        wdata_next = mem_wdata;
        done_next  = 1'b0;
        ill_next   = err_illegal;
        ovf_next   = err_overflow;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    addr_next  = '0;
                    wc_next    = '0;
                    ill_next   = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    w_en_next  = 1'b1;
                    maddr_next = addr_q;
                    wdata_next = word_c;
                    addr_next  = addr_q + ADDR_W'(1);
                    wc_next    = word_count + WC_W'(1);
                    if (illegal_c) ill_next = 1'b1;
                    if (cmd_last || addr_q == LAST_ADDR) state_next = FLUSH;
                    if (!cmd_last && addr_q == LAST_ADDR) ovf_next = 1'b1;
                end
            end
            FLUSH: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            word_count   <= '0;
            mem_w_en     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            cmd_ready    <= 1'b0;
            core_hold    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_next;
            addr_q       <= addr_next;
            word_count   <= wc_next;
            mem_w_en     <= w_en_next;
            mem_addr     <= maddr_next;
            mem_wdata    <= wdata_next;
            done         <= done_next;
            err_illegal  <= ill_next;
            err_overflow <= ovf_next;
            cmd_ready    <= (state_next == LOAD);
            core_hold    <= (state_next != IDLE);
            busy         <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a 1024-word loader plus a 4-word
// loader sharing the same stimulus for the overflow case.
module tb_program_loader;

    localparam int unsigned AW  = 10;
    localparam int unsigned SAW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, cmd_valid, cmd_last;
    logic [5:0]    cmd_opcode;
    logic [4:0]    cmd_dest, cmd_src1, cmd_src2;
    logic [15:0]   cmd_imm;

    logic          cmd_ready, mem_w_en, core_hold, busy, done, err_illegal, err_overflow;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;

    logic           s_cmd_ready, s_mem_w_en, s_core_hold, s_busy, s_done, s_err_illegal, s_err_overflow;
    logic [SAW-1:0] s_mem_addr;
    logic [31:0]    s_mem_wdata;
    logic [SAW:0]   s_word_count;

    program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_dest(cmd_dest), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_overflow(err_overflow), .word_count(word_count)
    );

    program_loader #(.ADDR_W(SAW)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_dest(cmd_dest), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last), .mem_w_en(s_mem_w_en), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .core_hold(s_core_hold), .busy(s_busy), .done(s_done),
        .err_illegal(s_err_illegal), .err_overflow(s_err_overflow), .word_count(s_word_count)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [15:0] imm;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        logic [31:0] w;
    } vec_t;

    int total = 0;
    int bad   = 0;

    cmd_t        cmd_q[$];
    logic [31:0] exp_q[$];
    vec_t        vec[10];

    int legal_ops[18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        for (int i = 0; i < 18; i++)
            if (int'(op) == legal_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference encoding taken straight from the field table.
    function automatic logic [31:0] ref_word(input cmd_t c, input int addr);
        logic [15:0] off;
        logic [4:0]  a, b;
        logic [15:0] lo;
        off = c.imm - 16'(addr + 1);
        if (!is_legal(c.op) || c.op == 6'd0) return 32'h0;
        if (c.op <= 6'd12) begin
            a = c.d;  b = c.s1; lo = {c.s2, 11'd0};
        end else if (c.op == 6'd32 || c.op == 6'd33 || c.op == 6'd36) begin
            a = c.d;  b = c.s1; lo = c.imm;
        end else if (c.op == 6'd37) begin
            a = c.s2; b = c.s1; lo = c.imm;
        end else if (c.op == 6'd40) begin
            a = c.s1; b = 5'd0; lo = off;
        end else if (c.op == 6'd41) begin
            a = c.s1; b = c.s2; lo = off;
        end else begin
            a = 5'd0; b = 5'd0; lo = off;
        end
        return {c.op, a, b, lo};
    endfunction

    function automatic cmd_t mkc(input int op, input int d, input int s1, input int s2, input int imm);
        cmd_t c;
        c.op = 6'(op); c.d = 5'(d); c.s1 = 5'(s1); c.s2 = 5'(s2); c.imm = 16'(imm);
        return c;
    endfunction

    function automatic vec_t mkv(input cmd_t c, input logic [31:0] w);
        vec_t v;
        v.c = c; v.w = w;
        return v;
    endfunction

    task automatic drive_cmd(input cmd_t c, input logic last);
        cmd_valid = 1'b1;
        cmd_opcode = c.op; cmd_dest = c.d; cmd_src1 = c.s1; cmd_src2 = c.s2; cmd_imm = c.imm;
        cmd_last = last;
    endtask

    task automatic drive_junk();
        cmd_valid = 1'b0;
        cmd_opcode = 6'($urandom); cmd_dest = 5'($urandom); cmd_src1 = 5'($urandom);
        cmd_src2 = 5'($urandom); cmd_imm = 16'($urandom); cmd_last = 1'($urandom);
    endtask

    // Loads cmd_q into the large loader and checks every write against exp_q.
    task automatic run_prog(input int pct, input int start_at, input logic exp_ill, input string tag);
        int n, idx, wr, first_w, last_w, last_acc;
        logic acc, seen_done;
        n = cmd_q.size();
        drive_junk();
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " ready_after_start"}, 32'(cmd_ready), 32'd1);
        chk({tag, " hold_after_start"}, 32'(core_hold), 32'd1);
        chk({tag, " count_cleared"}, 32'(word_count), 32'd0);
        chk({tag, " ill_cleared"}, 32'(err_illegal), 32'd0);
        idx = 0; wr = 0; first_w = -1; last_w = -1; last_acc = -1; seen_done = 1'b0;
        for (int cy = 0; cy < n * 20 + 20 && !seen_done; cy++) begin
            start = (cy == start_at);
            if (idx < n && int'($urandom_range(99)) < pct) drive_cmd(cmd_q[idx], idx == n - 1);
            else drive_junk();
            acc = cmd_valid && cmd_ready;
            step();
            chk({tag, " wen_follows_accept"}, 32'(mem_w_en), 32'(acc));
            if (mem_w_en) begin
                if (wr < n) begin
                    chk({tag, " addr"}, 32'(mem_addr), 32'(wr));
                    chk({tag, " data"}, mem_wdata, exp_q[wr]);
                end
                if (first_w < 0) first_w = cy;
                last_w = cy;
                wr++;
            end
            if (acc && idx == n - 1) begin
                chk({tag, " ready_in_flush"}, 32'(cmd_ready), 32'd0);
                chk({tag, " busy_in_flush"}, 32'(busy), 32'd1);
                last_acc = cy;
            end
            if (acc) idx++;
            if (done) begin
                seen_done = 1'b1;
                chk({tag, " done_latency"}, 32'(cy - last_acc), 32'd1);
                chk({tag, " hold_at_done"}, 32'(core_hold), 32'd0);
                chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
                chk({tag, " word_count"}, 32'(word_count), 32'(n));
                chk({tag, " err_illegal"}, 32'(err_illegal), 32'(exp_ill));
                chk({tag, " err_overflow"}, 32'(err_overflow), 32'd0);
            end
        end
        start = 1'b0;
        drive_junk();
        chk({tag, " done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, " write_total"}, 32'(wr), 32'(n));
        if (pct == 100) chk({tag, " consecutive_writes"}, 32'(last_w - first_w), 32'(n - 1));
        step();
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " ill_sticky"}, 32'(err_illegal), 32'(exp_ill));
    endtask

    task automatic ovf_test();
        int sidx, swr;
        logic acc, seen;
        cmd_t c;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        sidx = 0; swr = 0; seen = 1'b0;
        for (int k = 0; k < 15 && !seen; k++) begin
            drive_cmd(mkc(32, 1, 2, 0, sidx), sidx == 4);
            acc = s_cmd_ready;
            step();
            if (s_mem_w_en) begin
                c = mkc(32, 1, 2, 0, swr);
                chk("ovf addr", 32'(s_mem_addr), 32'(swr));
                chk("ovf data", s_mem_wdata, ref_word(c, swr));
                swr++;
            end
            if (acc && sidx == 3) begin
                chk("ovf ready_after_4th", 32'(s_cmd_ready), 32'd0);
                chk("ovf flag_after_4th", 32'(s_err_overflow), 32'd1);
            end
            if (acc) sidx++;
            if (s_done) seen = 1'b1;
        end
        drive_junk();
        chk("ovf done_seen", 32'(seen), 32'd1);
        chk("ovf writes", 32'(swr), 32'd4);
        chk("ovf accepts", 32'(sidx), 32'd4);
        chk("ovf word_count", 32'(s_word_count), 32'd4);
        chk("ovf flag_sticky", 32'(s_err_overflow), 32'd1);
        repeat (3) step();
    endtask

    task automatic reset_mid_load();
        start = 1'b1;
        step();
        start = 1'b0;
        drive_cmd(mkc(1, 3, 1, 2, 0), 1'b0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst flags", {25'd0, cmd_ready, mem_w_en, core_hold, busy, done, err_illegal, err_overflow}, 32'd0);
        chk("rst addr", 32'(mem_addr), 32'd0);
        chk("rst data", mem_wdata, 32'd0);
        chk("rst count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst ready_after", 32'(cmd_ready), 32'd0);
        chk("rst busy_after", 32'(busy), 32'd0);
        chk("rst wen_after", 32'(mem_w_en), 32'd0);
        drive_junk();
        step();
    endtask

    initial begin
        vec[0] = mkv(mkc(1, 3, 1, 2, 16'hFFFF), 32'h0461_1000);
        vec[1] = mkv(mkc(3, 31, 0, 31, 0), 32'h0FE0_F800);
        vec[2] = mkv(mkc(32, 1, 2, 7, 16'h1234), 32'h8022_1234);
        vec[3] = mkv(mkc(37, 7, 5, 9, 16'hABCD), 32'h9525_ABCD);
        vec[4] = mkv(mkc(41, 9, 2, 3, 10), 32'hA443_0005);
        vec[5] = mkv(mkc(42, 5, 6, 7, 0), 32'hA800_FFFA);
        vec[6] = mkv(mkc(0, 5, 6, 7, 16'h5555), 32'h0000_0000);
        vec[7] = mkv(mkc(36, 31, 31, 4, 16'h8000), 32'h93FF_8000);
        vec[8] = mkv(mkc(12, 1, 1, 1, 0), 32'h3021_0800);
        vec[9] = mkv(mkc(40, 3, 4, 9, 9), 32'hA080_FFFF);

        rst_n = 1'b0; start = 1'b0;
        drive_junk();
        repeat (3) @(posedge clk);
        #1;
        chk("reset flags", {25'd0, cmd_ready, mem_w_en, core_hold, busy, done, err_illegal, err_overflow}, 32'd0);
        chk("reset addr_data", 32'(mem_addr) | mem_wdata, 32'd0);
        chk("reset count", 32'(word_count), 32'd0);
        chk("reset small", {28'd0, s_cmd_ready, s_busy, s_core_hold, s_err_overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        cmd_q = {}; exp_q = {};
        cmd_q.push_back(vec[0].c); exp_q.push_back(32'h0461_1000);
        run_prog(100, -1, 1'b0, "single_add");

        cmd_q = {}; exp_q = {};
        for (int i = 0; i < 10; i++) begin
            cmd_q.push_back(vec[i].c);
            exp_q.push_back(vec[i].w);
        end
        run_prog(100, -1, 1'b0, "table");

        cmd_q = {}; exp_q = {};
        cmd_q.push_back(vec[0].c); exp_q.push_back(vec[0].w);
        cmd_q.push_back(vec[2].c); exp_q.push_back(vec[2].w);
        cmd_q.push_back(vec[8].c); exp_q.push_back(vec[8].w);
        cmd_q.push_back(mkc(40, 0, 4, 0, 0)); exp_q.push_back(32'hA080_FFFC);
        run_prog(100, -1, 1'b0, "bez_back");

        cmd_q = {}; exp_q = {};
        cmd_q.push_back(mkc(2, 3, 1, 2, 16'h7777)); exp_q.push_back(32'h0);
        run_prog(100, -1, 1'b1, "illegal");

        cmd_q = {}; exp_q = {};
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(mkc(33, i, i + 1, 0, i * 3));
            exp_q.push_back(ref_word(cmd_q[i], i));
        end
        run_prog(50, 3, 1'b0, "toggle_start");

        ovf_test();
        reset_mid_load();

        for (int r = 0; r < 8; r++) begin
            int n;
            logic ill;
            cmd_t c;
            cmd_q = {}; exp_q = {}; ill = 1'b0;
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) begin
                c = mkc(($urandom_range(7) == 0) ? int'($urandom_range(63)) : legal_ops[$urandom_range(17)],
                        int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
                        int'($urandom_range(65535)));
                if (!is_legal(c.op)) ill = 1'b1;
                cmd_q.push_back(c);
                exp_q.push_back(ref_word(c, i));
            end
            run_prog(int'($urandom_range(100, 30)), int'($urandom_range(n + 2)), ill, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Builds the instruction image for the pipeline processor at the far end of the opcode interface. It accepts decoded instruction commands over a valid/ready handshake and encodes each one into the 32-bit instruction word that the controller decodes. It writes each word to instruction memory at consecutive word addresses. While a load is in progress it holds the core in stall.

## Interface
- ADDR_W, 10, instruction memory word-address width; DEPTH = 2^ADDR_W words
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load from address 0 (honoured only in IDLE)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_opcode  in  6  instruction opcode
- cmd_dest, cmd_src1, cmd_src2  in  5 each  register numbers
- cmd_imm  in  16  immediate; for branches, the absolute target word address
- cmd_last  in  1  marks the final command of the program
- mem_w_en  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- core_hold  out  1  stalls the core while high
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a load completes
- err_illegal  out  1  sticky; an unknown opcode was seen
- err_overflow  out  1  sticky; memory filled before cmd_last
- word_count  out  ADDR_W+1  words written in current/last load

## Operation
- Opcode map: NOP 0, ADD 1, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLA 9, SLL 10, SRA 11, SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42. Any other value is illegal.
- Word fields: [31:26] opcode, [25:21] A, [20:16] B, [15:0] low.
- R-type (1–12): A=dest, B=src1, low={src2, 11'b0}.
- ADDI/SUBI/LD: A=dest, B=src1, low=imm.
- ST: A=src2 (the store-data register), B=src1, low=imm.
- BEZ: A=src1, B=0, low=offset.
- BNE: A=src1, B=src2, low=offset.
- JMP: A=0, B=0, low=offset.
- Branch offset: offset = cmd_imm − (write address + 1), computed in 16-bit two's-complement and wrapped mod 2^16.
- NOP encodes as 32'h0.
- Illegal opcode: the word is still written, as 32'h0; err_illegal is set and the address still advances.
- State machine: IDLE, LOAD, FLUSH.
  - IDLE, on start: address←0, word_count←0, both errors cleared → LOAD.
  - LOAD: cmd_ready=1. Each accept registers one write for the next cycle and increments the address.
  - An accept with cmd_last, or an accept at address DEPTH−1, goes to FLUSH. The accept at DEPTH−1 without cmd_last also sets err_overflow.
  - FLUSH: cmd_ready=0. Performs the final write, then goes to IDLE and pulses done.
- start outside IDLE is ignored.
- core_hold = 1 in LOAD and FLUSH; 0 in IDLE.

## Timing
- Reset values: cmd_ready, mem_w_en, core_hold, busy, done, both errors = 0; mem_addr, mem_wdata, word_count = 0; state IDLE.
- Reset mid-load aborts immediately. Memory contents already written are not undone.
- start at cycle t → LOAD, cmd_ready=1 and core_hold=1 at t+1.
- Accept at cycle t → mem_w_en=1 at t+1, with mem_addr=address at acceptance and word_count incremented at t+1.
- Back-to-back accepts give one write per cycle. Throughput is one word per cycle.
- Last accept at t:
  - t+1: FLUSH, the write occurs, cmd_ready=0.
  - t+2: IDLE, done=1 for one cycle, core_hold=0, busy=0.
- mem_wdata and mem_addr hold their last value when mem_w_en=0.
- Errors stay set after done, until the next accepted start or reset.

## Test plan
- ADD (op 1) with dest 3, src1 1, src2 2, cmd_last → at t+1 mem_w_en=1, addr 0, data 32'h0461_1000; done at t+2; word_count=1.
- Three back-to-back commands, then BEZ with src1 4 and target 0 at address 3:
  - writes occur on consecutive cycles;
  - the BEZ word is 32'hA080_FFFC (offset −4).
- Illegal opcode 2 at address 0 → data 32'h0, err_illegal=1 and stays set after done; next start clears it.
- ADDR_W=2: a 5-command stream → four writes at addresses 0..3, err_overflow=1, cmd_ready=0 after the 4th accept, done pulses, 5th command is never accepted.
- Reset asserted mid-load while cmd_valid=1 → all outputs 0 asynchronously; after release, state IDLE and cmd_ready=0.
- cmd_valid toggling 1/0 in LOAD, with start pulsed during LOAD → start ignored; writes only follow accepts; addresses contiguous.
